// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding imem reads, prefetch queue and IR.
// Optional stall counter output enabled by defining IFU_STALL_CNT_EN.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        E,
  input  logic        IR_E,
  input  logic        redir_valid,
  input  logic [15:0] redir_addr,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] IR,
  output logic [15:0] IR_PC,
  output logic        IR_valid,
  output logic        fetch_stall
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {RUN, WAIT, DROP, HALT} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } qent_t;

  localparam logic [1:0] LAST  = 2'(QDEPTH - 1);
  localparam logic [2:0] DEPTH = 3'(QDEPTH);

  state_t      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] req_addr_q;
  logic        halt_pend_q;

  qent_t       q_mem [0:3];
  logic [1:0]  head_q, tail_q;
  logic [2:0]  count_q;

  logic        outstanding, issue, ack_hit, push, pop, go_halt;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Request stays up from issue until ack; address is frozen while outstanding.
  always_comb begin
    outstanding = (state_q == WAIT) || (state_q == DROP);
    issue       = (state_q == RUN) && E && !halt && !rst && (count_q < DEPTH);
    imem_req    = issue || (outstanding && !rst);
    imem_addr   = outstanding ? req_addr_q : fetch_pc_q;
    ack_hit     = imem_req && imem_ack;
    push        = ack_hit && !redir_valid && (state_q != DROP);
    pop         = IR_E && E && (count_q != 3'd0) && !redir_valid;
    go_halt     = halt || halt_pend_q;
    fetch_stall = (count_q == 3'd0);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      RUN: begin
        if (issue) begin
          if (imem_ack) fetch_pc_d = fetch_pc_q + 16'd1;
          else          state_d    = redir_valid ? DROP : WAIT;
        end else if (halt) begin
          state_d = HALT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_d    = go_halt ? HALT : RUN;
          fetch_pc_d = req_addr_q + 16'd1;
        end else if (redir_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) state_d = go_halt ? HALT : RUN;
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
    // A redirect always owns the next fetch address, whatever the FSM does.
    if (redir_valid) fetch_pc_d = redir_addr;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      halt_pend_q <= 1'b0;
      head_q      <= 2'd0;
      tail_q      <= 2'd0;
      count_q     <= 3'd0;
      IR          <= 16'h0000;
      IR_PC       <= 16'h0000;
      IR_valid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      halt_pend_q <= halt_pend_q | halt;
      if (issue && !imem_ack) req_addr_q <= fetch_pc_q;

      if (redir_valid) begin
        head_q  <= 2'd0;
        tail_q  <= 2'd0;
        count_q <= 3'd0;
      end else begin
        if (push) tail_q <= ptr_inc(tail_q);
        if (pop)  head_q <= ptr_inc(head_q);
        if (push && !pop)      count_q <= count_q + 3'd1;
        else if (pop && !push) count_q <= count_q - 3'd1;
      end

      if (redir_valid) begin
        IR_valid <= 1'b0;
      end else if (IR_E && E) begin
        if (pop) begin
          IR       <= q_mem[head_q].instr;
          IR_PC    <= q_mem[head_q].pc;
          IR_valid <= 1'b1;
        end else begin
          IR_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst && push) q_mem[tail_q] <= {imem_rdata, imem_addr};
  end

`ifdef IFU_STALL_CNT_EN
  always_ff @(posedge CLK) begin
    if (rst)
      stall_cnt <= 16'h0000;
    else if (IR_E && E && (count_q == 3'd0) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit against a transaction-level queue model.
module tb_instr_fetch_unit;
  localparam int          QD  = 2;
  localparam logic [15:0] RPC = 16'h0000;

  logic        CLK = 1'b0;
  logic        rst = 1'b1, E = 1'b0, IR_E = 1'b0, redir_valid = 1'b0, halt = 1'b0;
  logic [15:0] redir_addr = 16'h0000;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_req, IR_valid, fetch_stall;
  logic [15:0] imem_addr, IR, IR_PC;
`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .CLK(CLK), .rst(rst), .E(E), .IR_E(IR_E), .redir_valid(redir_valid),
    .redir_addr(redir_addr), .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IR(IR), .IR_PC(IR_PC),
    .IR_valid(IR_valid), .fetch_stall(fetch_stall)
`ifdef IFU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // reference model state
  logic [15:0] m_qd[$], m_qa[$];
  logic [15:0] m_pc = RPC, m_oaddr = 16'h0000, m_ir = 16'h0000, m_irpc = 16'h0000;
  logic [15:0] m_stall = 16'h0000;
  bit          m_out = 0, m_drop = 0, m_halted = 0, m_irv = 0;

  // memory responder / scenario hooks
  bit          busy = 0, force_ack = 0, redir_on_ack = 0, fired = 0;
  int          lat = 0, waited = 0, fixlat = -1;
  logic [15:0] roa_addr = 16'h0000;
  logic [15:0] ld_ir[$], ld_pc[$];
  logic [15:0] ir_prev;

  int vecs = 0, errs = 0;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a + 16'h0800;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic req_s, ack_s, hs, exp_req, load;
    logic [15:0] addr_s, rd_s;
    #1;
    exp_req = !rst && (m_out || (!m_halted && !halt && E && (m_qa.size() < QD)));
    chk("imem_req", 16'(imem_req), 16'(exp_req));
    if (imem_req && exp_req) chk("imem_addr", imem_addr, m_out ? m_oaddr : m_pc);
    if (imem_req && m_irv && !rst)
      chk("addr_ahead", 16'((imem_addr - m_irpc) <= 16'(QD + 1)), 16'd1);
    if (rst) busy = 0;
    if (imem_req) begin
      if (!busy) begin
        busy = 1; waited = 0;
        lat = (fixlat >= 0) ? fixlat : $urandom_range(0, 3);
      end
      imem_ack = (waited == lat);
      waited++;
    end else begin
      imem_ack = force_ack;
    end
    imem_rdata = imem_ack ? mem(imem_addr) : 16'($urandom);
    if (imem_req && imem_ack) busy = 0;
    if (redir_on_ack && imem_req && imem_ack) begin
      redir_valid = 1; redir_addr = roa_addr; IR_E = 1; fired = 1; redir_on_ack = 0;
    end
    req_s = imem_req; ack_s = imem_ack; addr_s = imem_addr; rd_s = imem_rdata;
    @(posedge CLK);
    load = 0;
    if (rst) begin
      m_qd.delete(); m_qa.delete();
      m_pc = RPC; m_out = 0; m_drop = 0; m_halted = 0;
      m_ir = 16'h0000; m_irpc = 16'h0000; m_irv = 0; m_stall = 16'h0000;
    end else begin
      hs = req_s && ack_s;
      if (IR_E && E && m_qa.size() == 0 && m_stall != 16'hFFFF) m_stall++;
      if (redir_valid) m_irv = 0;
      else if (IR_E && E) begin
        if (m_qa.size() > 0) begin
          m_ir = m_qd.pop_front(); m_irpc = m_qa.pop_front(); m_irv = 1; load = 1;
        end else m_irv = 0;
      end
      if (hs) begin
        if (!redir_valid && !m_drop) begin
          m_qd.push_back(rd_s); m_qa.push_back(addr_s); m_pc = addr_s + 16'd1;
        end
        m_out = 0; m_drop = 0;
      end else if (req_s) begin
        if (!m_out) begin m_out = 1; m_oaddr = addr_s; end
        if (redir_valid) m_drop = 1;
      end
      if (redir_valid) begin m_qd.delete(); m_qa.delete(); m_pc = redir_addr; end
      if (halt) m_halted = 1;
    end
    #1;
    chk("IR", IR, m_ir);
    chk("IR_PC", IR_PC, m_irpc);
    chk("IR_valid", 16'(IR_valid), 16'(m_irv));
    chk("fetch_stall", 16'(fetch_stall), 16'(m_qa.size() == 0));
`ifdef IFU_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (load) begin ld_ir.push_back(IR); ld_pc.push_back(IR_PC); end
    imem_ack = 0; force_ack = 0;
  endtask

  initial begin
    // reset then zero-wait stream, IR_E every 4th cycle
    rst = 1; E = 1; repeat (3) step(); rst = 0; fixlat = 0;
    for (int i = 0; i < 16; i++) begin IR_E = (i % 4 == 3); step(); end
    IR_E = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stream_ir", ld_ir[i], 16'h0800 + 16'(i));
      chk("stream_pc", ld_pc[i], 16'(i));
    end

    // three wait states, IR_E held high
    ld_ir.delete(); ld_pc.delete(); fixlat = 3; IR_E = 1;
    repeat (40) step();
    IR_E = 0;
    chk("wait_loads", 16'(ld_pc.size() >= 8), 16'd1);
    for (int i = 1; i < ld_pc.size(); i++) chk("wait_seq", ld_pc[i], ld_pc[i-1] + 16'd1);

    // redirect while a request to 0005 is outstanding
    rst = 1; step(); rst = 0;
    E = 0; redir_valid = 1; redir_addr = 16'h0005; step();
    redir_valid = 0; E = 1; fixlat = 8; step(); step();
    chk("out_addr", imem_addr, 16'h0005);
    redir_valid = 1; redir_addr = 16'h00AB; step();
    redir_valid = 0; fixlat = 1; ld_ir.delete(); ld_pc.delete(); IR_E = 1;
    repeat (20) step();
    IR_E = 0;
    chk("redir_pc", ld_pc[0], 16'h00AB);
    chk("redir_ir", ld_ir[0], mem(16'h00AB));

    // redirect + IR_E + ack in one cycle
    rst = 1; step(); rst = 0; fixlat = 0;
    repeat (4) step();
    IR_E = 1; step(); IR_E = 0;
    fixlat = 2; fired = 0; roa_addr = 16'h0040; redir_on_ack = 1;
    for (int i = 0; i < 10 && !fired; i++) begin ir_prev = IR; step(); end
    chk("simul_fired", 16'(fired), 16'd1);
    chk("simul_ir", IR, ir_prev);
    chk("simul_irv", 16'(IR_valid), 16'd0);
    chk("simul_stall", 16'(fetch_stall), 16'd1);
    chk("simul_req", 16'(imem_req), 16'd1);
    chk("simul_addr", imem_addr, 16'h0040);
    redir_valid = 0; IR_E = 0; redir_on_ack = 0;

    // wrap at FFFF, then halt
    rst = 1; step(); rst = 0;
    E = 0; redir_valid = 1; redir_addr = 16'hFFFF; step();
    redir_valid = 0; E = 1; fixlat = 0; ld_ir.delete(); ld_pc.delete();
    for (int i = 0; i < 8; i++) begin IR_E = (i % 2 == 1); step(); end
    chk("wrap_pc0", ld_pc[0], 16'hFFFF);
    chk("wrap_pc1", ld_pc[1], 16'h0000);
    chk("wrap_ir1", ld_ir[1], mem(16'h0000));
    halt = 1; IR_E = 0; step(); halt = 0; IR_E = 1;
    for (int i = 0; i < 20; i++) begin step(); chk("halt_req", 16'(imem_req), 16'd0); end
    IR_E = 0;
    rst = 1; step(); rst = 0; #1;
    chk("resume_req", 16'(imem_req), 16'd1);
    chk("resume_addr", imem_addr, RPC);

    // late ack after reset must be ignored
    rst = 1; step(); rst = 0; E = 0; force_ack = 1; step(); E = 1;

    // stall counter: memory never acks
    rst = 1; step(); rst = 0; fixlat = 1000; IR_E = 1;
    repeat (5) step();
    IR_E = 0;
`ifdef IFU_STALL_CNT_EN
    chk("stall_cnt5", stall_cnt, 16'd5);
`endif
    rst = 1; step(); rst = 0;
`ifdef IFU_STALL_CNT_EN
    chk("stall_cnt_rst", stall_cnt, 16'd0);
`endif

    // random traffic
    fixlat = -1;
    repeat (800) begin
      E           = ($urandom_range(0, 9) != 0);
      IR_E        = ($urandom_range(0, 1) == 1);
      redir_valid = ($urandom_range(0, 29) == 0);
      redir_addr  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFFE;
      halt        = ($urandom_range(0, 99) == 0);
      rst         = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 0; E = 0; IR_E = 0; redir_valid = 0; halt = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of Controller16bit_Complete: owns the fetch PC, issues word reads to instruction memory and buffers returned words in a small prefetch queue.
- Presents the 16-bit IR to the controller, loading the next word on each controller IR_E pulse.
- Accepts PC redirects (branch/jump/JR) from the controller/datapath, flushing stale prefetches.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.
- QDEPTH, 2, prefetch queue entries (2..4).

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- E  input  1  global enable; low freezes the issue and IR load.
- IR_E  input  1  controller strobe: load the next instruction into IR.
- redir_valid  input  1  PC redirect request.
- redir_addr  input  16  redirect target (word address).
- halt  input  1  controller done/HLT; stops further fetching.
- imem_req  output  1  memory read request.
- imem_addr  output  16  memory word address.
- imem_ack  input  1  read complete; imem_rdata valid this cycle.
- imem_rdata  input  16  returned instruction word.
- IR  output  16  current instruction.
- IR_PC  output  16  address of current IR.
- IR_valid  output  1  IR holds a valid instruction.
- fetch_stall  output  1  queue empty (IR_E would bubble).

Behaviour:
- Reset values: imem_req=0, imem_addr=RESET_PC, IR=16'h0000, IR_PC=16'h0000, IR_valid=0, queue empty, fetch_stall=1, FSM=RUN, fetch PC=RESET_PC.
- FSM states:
  - RUN: may issue.
  - WAIT: one request outstanding.
  - DROP: outstanding response must be discarded.
  - HALT: no issue.
- Issue (RUN): imem_req=1 and imem_addr=fetch PC when E=1, halt=0, and count+outstanding < QDEPTH. At most one outstanding request.
- Handshake: imem_req and imem_addr stay stable until imem_ack.
  - Ack is allowed in the same cycle req rises (zero wait) or any later cycle.
  - On ack: push {imem_rdata, addr} to the queue, fetch PC += 1 (16-bit wrap, FFFF→0000), then RUN.
  - Without ack, the FSM is in WAIT.
- IR load: on IR_E=1, E=1, queue non-empty → IR/IR_PC ← head, pop, IR_valid=1, one-cycle latency (visible the next cycle).
  - IR_E with an empty queue → IR held, IR_valid=0.
- Push and pop in the same cycle are both allowed; count is unchanged.
- fetch_stall = (count==0), combinational from registered state.
- Redirect (redir_valid=1, regardless of E):
  - Flush the queue, set fetch PC=redir_addr, IR_valid=0.
  - An IR_E in the same cycle is ignored; redirect wins.
  - Ack in the same cycle: data discarded, go RUN.
  - Request outstanding without ack: go DROP. imem_req stays high until ack, that ack's data is discarded, then RUN issues at redir_addr.
  - Redirect while in DROP: update the target only.
- Halt: halt=1 in RUN → HALT, no new requests. An outstanding request completes and pushes normally. Queue and IR_E continue to work. Only rst leaves HALT; redirect in HALT updates the PC but does not issue.
- E=0: no new issue, no IR load. Outstanding ack is still captured to honour the handshake.
- rst mid-transaction: all state cleared next edge; imem_req drops; a late ack after reset is ignored (FSM RUN with outstanding=0 ignores acks).

Optional Feature:
- Macro IFU_STALL_CNT_EN.
- Defined: extra output stall_cnt[15:0], reset 0. Increments each cycle IR_E=1, E=1 and the queue is empty. Saturates at 16'hFFFF; cleared only by rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset/stream: rst 3 cycles, zero-wait memory returning mem[a]=a+16'h0800, IR_E every 4th cycle → IR sequence 0800,0801,0802 with IR_PC 0000,0001,0002; imem_addr never exceeds IR_PC+QDEPTH+1.
- Wait states: ack 3 cycles after req, IR_E held high → imem_addr stable while waiting; fetch_stall=1 between words; no word lost or duplicated.
- Redirect during outstanding: redir_valid with addr 16'h00AB while a request to 0005 awaits ack → the 0005 data is dropped; next req addr=00AB; next IR=mem[00AB], IR_PC=00AB.
- Simultaneous redirect+IR_E+ack: all in one cycle with redir_addr 0040 → IR unchanged, IR_valid=0, queue empty, next req 0040.
- Halt/wrap: redirect to FFFF, fetch 2 words → IR_PC FFFF then 0000. Then halt=1 → imem_req stays 0 for 20 cycles; rst resumes at RESET_PC.
- IFU_STALL_CNT_EN: IR_E high 5 cycles on an empty queue with memory never acking → stall_cnt=5; rst → 0.
